// File: rtl/dut_bus_pkg.sv
// Shared register map, FSM state encoding and decode helpers for the bus master.
package dut_bus_pkg;

  localparam int unsigned ADDR_W = 3;

  localparam logic [ADDR_W-1:0] ADDR_A_NOTFULL  = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_B_NOTFULL  = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_Y_NOTEMPTY = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_Y_DATA     = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_A_DATA     = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_B_DATA     = 3'd5;

  typedef enum logic [2:0] {
    IDLE, POLL_A, WR_A, POLL_B, WR_B, POLL_Y, RD_Y, RSP
  } state_t;

  // True in the three status-polling states.
  function automatic logic is_poll(input state_t s);
    return (s == POLL_A) || (s == POLL_B) || (s == POLL_Y);
  endfunction

  // True in every state that drives the read strobe.
  function automatic logic is_read(input state_t s);
    return is_poll(s) || (s == RD_Y);
  endfunction

  // True in the two write states.
  function automatic logic is_write(input state_t s);
    return (s == WR_A) || (s == WR_B);
  endfunction

  // Read address driven while in a given state.
  function automatic logic [ADDR_W-1:0] read_addr_of(input state_t s);
    case (s)
      POLL_A:  return ADDR_A_NOTFULL;
      POLL_B:  return ADDR_B_NOTFULL;
      POLL_Y:  return ADDR_Y_NOTEMPTY;
      RD_Y:    return ADDR_Y_DATA;
      default: return '0;
    endcase
  endfunction

  // Write address driven while in a given state.
  function automatic logic [ADDR_W-1:0] write_addr_of(input state_t s);
    case (s)
      WR_A:    return ADDR_A_DATA;
      WR_B:    return ADDR_B_DATA;
      default: return '0;
    endcase
  endfunction

  // Protocol sequencing: one step of the transaction walk.
  function automatic state_t next_state(input state_t s, input logic req_valid,
                                        input logic poll_ok, input logic expired,
                                        input logic write_rdy, input logic read_rdy,
                                        input logic rsp_ready);
    state_t n;
    n = s;
    case (s)
      IDLE:    if (req_valid) n = POLL_A;
      POLL_A:  if (poll_ok) n = WR_A; else if (expired) n = RSP;
      WR_A:    if (write_rdy) n = POLL_B;
      POLL_B:  if (poll_ok) n = WR_B; else if (expired) n = RSP;
      WR_B:    if (write_rdy) n = POLL_Y;
      POLL_Y:  if (poll_ok) n = RD_Y; else if (expired) n = RSP;
      RD_Y:    if (read_rdy) n = RSP;
      RSP:     if (rsp_ready) n = IDLE;
      default: n = IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/dut_poll_timer.sv
// Per-poll-state cycle counter; expired marks the last permitted poll cycle.
module dut_poll_timer #(
  parameter int unsigned POLL_LIMIT = 1000,
  parameter int unsigned CNT_W      = 10
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] poll_cnt;

  // Count unsuccessful poll cycles; cleared whenever the FSM is outside a poll state.
  always_ff @(posedge CLK) begin
    if (!RST_N || clear) begin
      poll_cnt <= '0;
    end else if (enable && !expired) begin
      poll_cnt <= poll_cnt + CNT_W'(1);
    end
  end

  assign expired = (poll_cnt == CNT_W'(POLL_LIMIT - 1));

endmodule

// File: rtl/dut_bus_master.sv
// Bus initiator running the OR responder's register protocol for each request.
module dut_bus_master
  import dut_bus_pkg::*;
#(
  parameter int unsigned POLL_LIMIT = 1000,
  parameter int unsigned CNT_W      = 10
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_a,
  input  logic              req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_y,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] write_address,
  output logic              write_data,
  output logic              write_en,
  input  logic              write_rdy,
  output logic [ADDR_W-1:0] read_address,
  output logic              read_en,
  input  logic              read_data,
  input  logic              read_rdy,
  output logic [15:0]       txn_count,
  output logic [7:0]        err_count
);

  state_t state;
  state_t nxt;
  logic   idle_q;
  logic   a_q;
  logic   b_q;
  logic   in_poll;
  logic   poll_ok;
  logic   expired;
  logic   timeout_hit;

  assign in_poll     = is_poll(state);
  assign poll_ok     = read_rdy & read_data;
  assign timeout_hit = in_poll & ~poll_ok & expired;
  assign req_ready   = idle_q & RST_N;
  assign nxt         = next_state(state, req_valid, poll_ok, expired,
                                  write_rdy, read_rdy, rsp_ready);

  dut_poll_timer #(
    .POLL_LIMIT(POLL_LIMIT),
    .CNT_W     (CNT_W)
  ) u_poll_timer (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .clear  (~in_poll),
    .enable (in_poll & ~poll_ok),
    .expired(expired)
  );

  // State register, registered bus decode of the next state, and response/counter updates.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state         <= IDLE;
      idle_q        <= 1'b1;
      a_q           <= 1'b0;
      b_q           <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_y         <= 1'b0;
      rsp_timeout   <= 1'b0;
      write_address <= '0;
      write_data    <= 1'b0;
      write_en      <= 1'b0;
      read_address  <= '0;
      read_en       <= 1'b0;
      txn_count     <= '0;
      err_count     <= '0;
    end else begin
      state         <= nxt;
      idle_q        <= (nxt == IDLE);
      rsp_valid     <= (nxt == RSP);
      read_en       <= is_read(nxt);
      read_address  <= read_addr_of(nxt);
      write_en      <= is_write(nxt);
      write_address <= write_addr_of(nxt);
      write_data    <= (nxt == WR_A) ? a_q : ((nxt == WR_B) ? b_q : 1'b0);

      if (state == IDLE && req_valid) begin
        a_q <= req_a;
        b_q <= req_b;
      end

      if (timeout_hit) begin
        rsp_y       <= 1'b0;
        rsp_timeout <= 1'b1;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end

      if (state == RD_Y && read_rdy) begin
        rsp_y       <= read_data;
        rsp_timeout <= 1'b0;
      end

      if (state == RSP && rsp_ready) begin
        txn_count   <= txn_count + 16'd1;
        rsp_y       <= 1'b0;
        rsp_timeout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dut_bus_master.sv
// Directed bench: main master against a behavioural OR responder, plus a short-limit
// master against a status stub for exact-latency and timeout scenarios.
module tb_dut_bus_master;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  // Main instance signals
  logic       req_valid, req_ready, req_a, req_b;
  logic       rsp_valid, rsp_ready, rsp_y, rsp_timeout;
  logic [2:0] write_address, read_address;
  logic       write_data, write_en, write_rdy;
  logic       read_en, read_data, read_rdy;
  logic [15:0] txn_count;
  logic [7:0]  err_count;

  // Short-limit instance signals
  logic       t_req_valid, t_req_ready, t_req_a, t_req_b;
  logic       t_rsp_valid, t_rsp_ready, t_rsp_y, t_rsp_timeout;
  logic [2:0] t_write_address, t_read_address;
  logic       t_write_data, t_write_en;
  logic       t_read_en, t_read_data;
  logic [15:0] t_txn_count;
  logic [7:0]  t_err_count;
  logic       stub_ok, stub_y;

  int checks = 0;
  int errors = 0;

  dut_bus_master dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_timeout(rsp_timeout),
    .write_address(write_address), .write_data(write_data), .write_en(write_en),
    .write_rdy(write_rdy), .read_address(read_address), .read_en(read_en),
    .read_data(read_data), .read_rdy(read_rdy), .txn_count(txn_count), .err_count(err_count)
  );

  dut_bus_master #(.POLL_LIMIT(20), .CNT_W(5)) dut_to (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(t_req_valid), .req_ready(t_req_ready), .req_a(t_req_a), .req_b(t_req_b),
    .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready), .rsp_y(t_rsp_y),
    .rsp_timeout(t_rsp_timeout), .write_address(t_write_address),
    .write_data(t_write_data), .write_en(t_write_en), .write_rdy(1'b1),
    .read_address(t_read_address), .read_en(t_read_en), .read_data(t_read_data),
    .read_rdy(1'b1), .txn_count(t_txn_count), .err_count(t_err_count)
  );

  // Status stub: FIFOs always have space, y-not-empty and y data under bench control.
  assign t_read_data = (t_read_address == 3'd2) ? stub_ok :
                       (t_read_address == 3'd3) ? stub_y  : 1'b1;

  // Behavioural OR responder: single-entry a/b/y registers, result after y_delay cycles.
  logic a_v, a_d, b_v, b_d, y_v, y_d;
  int   dly, y_delay;
  int   wr4_cnt, wr5_cnt, rd3_cnt;

  always_comb begin
    case (read_address)
      3'd0:    read_data = ~a_v;
      3'd1:    read_data = ~b_v;
      3'd2:    read_data = y_v;
      3'd3:    read_data = y_d;
      default: read_data = 1'b0;
    endcase
  end

  always @(posedge CLK) begin
    if (!RST_N) begin
      a_v <= 1'b0; b_v <= 1'b0; y_v <= 1'b0; dly <= 0;
    end else begin
      if (a_v && b_v && !y_v) begin
        if (dly >= y_delay) begin
          y_v <= 1'b1; y_d <= a_d | b_d; a_v <= 1'b0; b_v <= 1'b0; dly <= 0;
        end else begin
          dly <= dly + 1;
        end
      end
      if (write_en && write_rdy && write_address == 3'd4) begin
        a_v <= 1'b1; a_d <= write_data; wr4_cnt <= wr4_cnt + 1;
      end
      if (write_en && write_rdy && write_address == 3'd5) begin
        b_v <= 1'b1; b_d <= write_data; wr5_cnt <= wr5_cnt + 1;
      end
      if (read_en && read_rdy && read_address == 3'd3) begin
        y_v <= 1'b0; rd3_cnt <= rd3_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Offer a request and return at the negedge of cycle 1 after the handshake.
  task automatic send_req(input int which, input logic a, input logic b);
    int n;
    @(negedge CLK);
    if (which == 0) begin req_valid = 1'b1; req_a = a; req_b = b; end
    else begin t_req_valid = 1'b1; t_req_a = a; t_req_b = b; end
    n = 0;
    while (((which == 0) ? req_ready : t_req_ready) !== 1'b1 && n < 50) begin
      @(negedge CLK); n++;
    end
    check("req_accept", 32'((which == 0) ? req_ready : t_req_ready), 32'd1);
    @(negedge CLK);
    req_valid = 1'b0; t_req_valid = 1'b0;
  endtask

  // Count cycles from the handshake until rsp_valid (cycle 1 = first cycle after it).
  task automatic wait_rsp(input int which, output int lat);
    lat = 1;
    while (((which == 0) ? rsp_valid : t_rsp_valid) !== 1'b1 && lat < 3000) begin
      @(negedge CLK); lat++;
    end
    check("rsp_arrive", 32'((which == 0) ? rsp_valid : t_rsp_valid), 32'd1);
  endtask

  task automatic ack_rsp(input int which);
    if (which == 0) rsp_ready = 1'b1; else t_rsp_ready = 1'b1;
    @(negedge CLK);
    rsp_ready = 1'b0; t_rsp_ready = 1'b0;
  endtask

  initial begin
    int lat, n, en4, w4, w5, r3;
    logic d0, stable, hold_ok;
    logic [1:0] vec_a, vec_b, vec_y;
    logic [3:0] va, vb, vy;

    RST_N = 1'b0;
    req_valid = 0; req_a = 0; req_b = 0; rsp_ready = 0;
    t_req_valid = 0; t_req_a = 0; t_req_b = 0; t_rsp_ready = 0;
    write_rdy = 1'b1; read_rdy = 1'b1;
    stub_ok = 1'b1; stub_y = 1'b1;
    y_delay = 0; wr4_cnt = 0; wr5_cnt = 0; rd3_cnt = 0;
    vec_a = 0; vec_b = 0; vec_y = 0;

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_idle_bus", 32'({rsp_valid, rsp_y, rsp_timeout, write_en, read_en,
                               write_address, read_address, write_data}), 32'd0);
    check("rst_counts", 32'({txn_count, err_count}), 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);
    check("idle_req_ready", 32'(req_ready), 32'd1);

    // Four OR vectors against the responder
    va = 4'b1001; vb = 4'b1100; vy = 4'b1101;  // pairs (1,0),(0,0),(0,1),(1,1)
    for (int i = 3; i >= 0; i--) begin
      send_req(0, va[i], vb[i]);
      wait_rsp(0, lat);
      if (i == 3) check("lat_resp_d0", 32'(lat), 32'd8);
      check($sformatf("or_y_%0d", 3 - i), 32'(rsp_y), 32'(vy[i]));
      check($sformatf("or_to_%0d", 3 - i), 32'(rsp_timeout), 32'd0);
      ack_rsp(0);
    end
    check("txn_count_4", 32'(txn_count), 32'd4);

    // Slow responder: result after 250 extra cycles, one access per data register
    y_delay = 250; w4 = wr4_cnt; w5 = wr5_cnt; r3 = rd3_cnt;
    send_req(0, 1'b0, 1'b1);
    wait_rsp(0, lat);
    check("slow_lat", 32'(lat), 32'd258);
    check("slow_y", 32'(rsp_y), 32'd1);
    ack_rsp(0);
    check("slow_access", 32'({wr4_cnt - w4, wr5_cnt - w5, rd3_cnt - r3}),
          32'({32'd1, 32'd1, 32'd1}));
    y_delay = 0;

    // Write stall: write_rdy low for the first 5 WR_A cycles
    write_rdy = 1'b0; w4 = wr4_cnt; en4 = 0; stable = 1'b1; d0 = 1'b0; n = 0;
    send_req(0, 1'b1, 1'b0);
    while (n < 100) begin
      if (write_en && write_address == 3'd4) begin
        en4++;
        if (en4 == 1) d0 = write_data;
        else if (write_data !== d0) stable = 1'b0;
        if (en4 == 6) write_rdy = 1'b1;
      end else if (en4 > 0) begin
        break;
      end
      @(negedge CLK); n++;
    end
    write_rdy = 1'b1;
    check("stall_en_cycles", 32'(en4), 32'd6);
    check("stall_data", 32'({stable, d0}), 32'b11);
    wait_rsp(0, lat);
    check("stall_y", 32'(rsp_y), 32'd1);
    ack_rsp(0);
    check("stall_one_write", 32'(wr4_cnt - w4), 32'd1);

    // Response back-pressure with a new request waiting
    send_req(0, 1'b0, 1'b0);
    wait_rsp(0, lat);
    req_valid = 1'b1; req_a = 1'b1; req_b = 1'b0;
    hold_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (rsp_valid !== 1'b1 || rsp_y !== 1'b0 || req_ready !== 1'b0) hold_ok = 1'b0;
    end
    check("rsp_hold", 32'(hold_ok), 32'd1);
    rsp_ready = 1'b1;
    @(negedge CLK);
    rsp_ready = 1'b0;
    check("post_hs_idle", 32'({req_ready, rsp_valid}), 32'b10);
    @(negedge CLK);
    req_valid = 1'b0;
    check("next_accepted", 32'({req_ready, read_en, read_address}), 32'b01000);
    wait_rsp(0, lat);
    check("next_lat", 32'(lat), 32'd8);
    check("next_y", 32'(rsp_y), 32'd1);
    ack_rsp(0);

    // Short-limit instance: minimum latency with all status set
    send_req(1, 1'b1, 1'b0);
    wait_rsp(1, lat);
    check("min_lat", 32'(lat), 32'd7);
    check("min_y", 32'({t_rsp_y, t_rsp_timeout}), 32'b10);
    ack_rsp(1);

    // Short-limit instance: y-not-empty stuck low -> timeout
    stub_ok = 1'b0;
    send_req(1, 1'b1, 1'b1);
    wait_rsp(1, lat);
    check("to_lat", 32'(lat), 32'd25);
    check("to_flags", 32'({t_rsp_y, t_rsp_timeout}), 32'b01);
    check("to_err_count", 32'(t_err_count), 32'd1);
    ack_rsp(1);
    check("to_txn_count", 32'(t_txn_count), 32'd2);
    stub_ok = 1'b1;

    // Reset during POLL_Y, then a clean transaction
    y_delay = 100;
    send_req(0, 1'b1, 1'b0);
    n = 0;
    while (!(read_en && read_address == 3'd2) && n < 50) begin @(negedge CLK); n++; end
    check("reach_poll_y", 32'(read_en && read_address == 3'd2), 32'd1);
    RST_N = 1'b0;
    @(negedge CLK);
    check("mid_rst_bus", 32'({req_ready, rsp_valid, read_en, write_en, read_address}), 32'd0);
    check("mid_rst_counts", 32'({txn_count, err_count}), 32'd0);
    RST_N = 1'b1;
    y_delay = 0;
    send_req(0, 1'b0, 1'b1);
    wait_rsp(0, lat);
    check("fresh_lat", 32'(lat), 32'd8);
    check("fresh_y", 32'({rsp_y, rsp_timeout}), 32'b10);
    ack_rsp(0);
    check("fresh_txn_count", 32'(txn_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
